// File: rtl/alu_test_driver.sv
// -----------------------------------------------------------------------------
// alu_test_driver
//   Self-checking stimulus source for a 4-bit ALU. A 16-bit Galois LFSR
//   (right shift, taps 16'hB400) produces one operand/opcode vector per cycle.
//   The vector is driven onto the ALU inputs from registers. On the next edge
//   the combinational ALU response is compared with an internal golden model.
//   The block counts vectors and mismatches and records the first failing
//   vector.
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   start           in   run request, honoured only in IDLE or DONE
//   alu_a/alu_b     out  4-bit operands driven to the ALU (registered)
//   alu_opcode      out  3-bit opcode driven to the ALU (registered)
//   alu_result      in   ALU result for the currently driven vector
//   alu_zero        in   ALU zero flag for the currently driven vector
//   busy            out  high while a run is in progress
//   done            out  high once the run has finished, held until next start
//   pass            out  valid with done: no mismatching vector in the run
//   vec_count       out  vectors checked in the current run
//   err_count       out  mismatching vectors (saturating)
//   first_err_valid out  a mismatch has been captured this run
//   first_err_vec   out  {opcode, a, b} of the first mismatching vector
// -----------------------------------------------------------------------------
module alu_test_driver #(
  parameter int          NUM_VECTORS = 256,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [3:0]       alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [10:0]      first_err_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [3:0] golden(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    logic [3:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = {3'b000, (a == b)};
      3'd6:    r = {3'b000, (a < b)};
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             done_q, done_d, pass_q, pass_d;
  logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d;
  logic             fev_q, fev_d;
  logic [10:0]      fe_q, fe_d;

  logic [3:0]       exp_res;
  logic             mismatch;
  logic [15:0]      lfsr_adv;
  logic [CNT_W-1:0] vec_inc;
  logic [CNT_W-1:0] err_inc;

  assign exp_res  = golden(a_q, b_q, op_q);
  assign mismatch = (alu_result != exp_res) || (alu_zero != (exp_res == 4'h0));
  assign lfsr_adv = lfsr_next(lfsr_q);
  assign vec_inc  = vec_q + 1'b1;
  assign err_inc  = (err_q == CNT_MAX) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    done_d  = done_q;
    pass_d  = pass_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fe_d    = fe_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          lfsr_d  = SEED_EFF;
          a_d     = SEED_EFF[3:0];
          b_d     = SEED_EFF[7:4];
          op_d    = SEED_EFF[10:8];
          done_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fe_d    = '0;
        end
      end
      RUN: begin
        vec_d = vec_inc;
        if (mismatch) begin
          err_d = err_inc;
          if (!fev_q) begin
            fev_d = 1'b1;
            fe_d  = {op_q, a_q, b_q};
          end
        end
        if (vec_inc == NUM_C) begin
          // Last vector checked: the ALU inputs keep the final vector.
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          lfsr_d = lfsr_adv;
          a_d    = lfsr_adv[3:0];
          b_d    = lfsr_adv[7:4];
          op_d   = lfsr_adv[10:8];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vec_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fe_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fe_q    <= fe_d;
    end
  end

  assign alu_a           = a_q;
  assign alu_b           = b_q;
  assign alu_opcode      = op_q;
  assign busy            = (state_q == RUN);
  assign done            = done_q;
  assign pass            = pass_q;
  assign vec_count       = vec_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fe_q;

endmodule

// File: tb/tb_alu_test_driver.sv
module tb_alu_test_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   fmode = 0;   // 0 good ALU, 1 zero flag stuck 0, 2 corrupt a value class
  int   fkey  = 0;

  localparam logic [15:0] SEED0 = 16'hACE1;
  localparam logic [15:0] SEED1 = 16'h0000;
  localparam logic [15:0] SEED2 = 16'h1234;

  // Reference ALU behaviour in plain integer arithmetic.
  function automatic logic [3:0] ref_op(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      3'd0:    r = (ai + bi) % 16;
      3'd1:    r = (ai - bi + 16) % 16;
      3'd2:    r = ai & bi;
      3'd3:    r = ai | bi;
      3'd4:    r = ai ^ bi;
      3'd5:    r = (ai == bi) ? 1 : 0;
      3'd6:    r = (ai < bi) ? 1 : 0;
      default: r = 0;
    endcase
    return 4'(r);
  endfunction

  // Bench-side ALU with optional planted faults; returns {zero, result}.
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op, input int mode,
                                           input int key);
    logic [3:0] r;
    logic       z;
    r = ref_op(a, b, op);
    z = (r == 4'h0);
    if (mode == 1) z = 1'b0;
    if (mode == 2 && (int'({op, a, b}) % 7) == key) begin
      r = r ^ 4'h1;
      z = (r == 4'h0);
    end
    return {z, r};
  endfunction

  // Three instances: the 4-vector reference run, a long run with zero seed,
  // and a single-vector run.
  logic [3:0]  d0_a, d0_b, d0_res, d1_a, d1_b, d1_res, d2_a, d2_b, d2_res;
  logic [2:0]  d0_op, d1_op, d2_op;
  logic        d0_zero, d1_zero, d2_zero;
  logic        d0_start, d1_start, d2_start;
  logic        d0_busy, d1_busy, d2_busy, d0_done, d1_done, d2_done;
  logic        d0_pass, d1_pass, d2_pass, d0_fev, d1_fev, d2_fev;
  logic [15:0] d0_vc, d1_vc, d2_vc, d0_ec, d1_ec, d2_ec;
  logic [10:0] d0_fe, d1_fe, d2_fe;
  logic        d0_done_q = 1'b0, d1_done_q = 1'b0, d2_done_q = 1'b0;

  assign {d0_zero, d0_res} = alu_model(d0_a, d0_b, d0_op, fmode, fkey);
  assign {d1_zero, d1_res} = alu_model(d1_a, d1_b, d1_op, fmode, fkey);
  assign {d2_zero, d2_res} = alu_model(d2_a, d2_b, d2_op, fmode, fkey);

  alu_test_driver #(.NUM_VECTORS(4), .SEED(SEED0), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(d0_start), .alu_a(d0_a), .alu_b(d0_b),
    .alu_opcode(d0_op), .alu_result(d0_res), .alu_zero(d0_zero), .busy(d0_busy),
    .done(d0_done), .pass(d0_pass), .vec_count(d0_vc), .err_count(d0_ec),
    .first_err_valid(d0_fev), .first_err_vec(d0_fe));

  alu_test_driver #(.NUM_VECTORS(200), .SEED(SEED1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(d1_start), .alu_a(d1_a), .alu_b(d1_b),
    .alu_opcode(d1_op), .alu_result(d1_res), .alu_zero(d1_zero), .busy(d1_busy),
    .done(d1_done), .pass(d1_pass), .vec_count(d1_vc), .err_count(d1_ec),
    .first_err_valid(d1_fev), .first_err_vec(d1_fe));

  alu_test_driver #(.NUM_VECTORS(1), .SEED(SEED2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(d2_start), .alu_a(d2_a), .alu_b(d2_b),
    .alu_opcode(d2_op), .alu_result(d2_res), .alu_zero(d2_zero), .busy(d2_busy),
    .done(d2_done), .pass(d2_pass), .vec_count(d2_vc), .err_count(d2_ec),
    .first_err_valid(d2_fev), .first_err_vec(d2_fe));

  typedef struct {
    int          sel;
    logic [10:0] v;
  } vec_t;

  typedef struct {
    int          sel;
    int          vc;
    int          ec;
    logic        pass;
    logic        fev;
    logic [10:0] fe;
  } fin_t;

  vec_t vq[$];
  fin_t fq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected vector stream and final summary for one run.
  task automatic plan(input int sel, input int nv, input logic [15:0] seed);
    logic [15:0] s;
    logic [3:0]  a, b, g;
    logic [2:0]  op;
    logic [4:0]  o;
    fin_t        f;
    s = (seed == 16'h0000) ? 16'h0001 : seed;
    f.sel = sel; f.vc = nv; f.ec = 0; f.fev = 1'b0; f.fe = '0;
    for (int i = 0; i < nv; i++) begin
      a  = s[3:0];
      b  = s[7:4];
      op = s[10:8];
      vq.push_back('{sel, {op, a, b}});
      o = alu_model(a, b, op, fmode, fkey);
      g = ref_op(a, b, op);
      if (o[3:0] != g || o[4] != (g == 4'h0)) begin
        f.ec++;
        if (!f.fev) begin
          f.fev = 1'b1;
          f.fe  = {op, a, b};
        end
      end
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
    f.pass = (f.ec == 0);
    fq.push_back(f);
  endtask

  task automatic mon_vec(input int sel, input logic [10:0] v);
    vec_t e;
    if (vq.size() == 0) begin
      total++; bad++;
      $display("FAIL vec_unexpected dut=%0d actual=%0h required=none", sel, v);
    end else begin
      e = vq.pop_front();
      check("vec_dut", sel, e.sel);
      check("vec_fields", v, e.v);
    end
  endtask

  task automatic mon_fin(input int sel, input logic [15:0] vc, input logic [15:0] ec,
                         input logic ps, input logic fev, input logic [10:0] fe,
                         input logic bsy);
    fin_t e;
    if (fq.size() == 0) begin
      total++; bad++;
      $display("FAIL done_unexpected dut=%0d actual=1 required=0", sel);
    end else begin
      e = fq.pop_front();
      check("fin_dut", sel, e.sel);
      check("fin_vec_count", vc, e.vc);
      check("fin_err_count", ec, e.ec);
      check("fin_pass", ps, e.pass);
      check("fin_first_err_valid", fev, e.fev);
      check("fin_first_err_vec", fe, e.fe);
      check("fin_busy", bsy, 1'b0);
    end
  endtask

  // Monitor: consumes one expected vector per RUN cycle and a summary at done.
  always @(negedge clk) begin
    if (d0_busy) mon_vec(0, {d0_op, d0_a, d0_b});
    if (d1_busy) mon_vec(1, {d1_op, d1_a, d1_b});
    if (d2_busy) mon_vec(2, {d2_op, d2_a, d2_b});
    if (d0_done && !d0_done_q) mon_fin(0, d0_vc, d0_ec, d0_pass, d0_fev, d0_fe, d0_busy);
    if (d1_done && !d1_done_q) mon_fin(1, d1_vc, d1_ec, d1_pass, d1_fev, d1_fe, d1_busy);
    if (d2_done && !d2_done_q) mon_fin(2, d2_vc, d2_ec, d2_pass, d2_fev, d2_fe, d2_busy);
    d0_done_q <= d0_done;
    d1_done_q <= d1_done;
    d2_done_q <= d2_done;
  end

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       d0_start = v;
      1:       d1_start = v;
      default: d2_start = v;
    endcase
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? d0_done : (sel == 1) ? d1_done : d2_done;
  endfunction

  function automatic logic [15:0] get_vc(input int sel);
    return (sel == 0) ? d0_vc : (sel == 1) ? d1_vc : d2_vc;
  endfunction

  // One full run; poke > 0 re-asserts start through edge 'poke' of the run.
  task automatic run(input int sel, input int nv, input logic [15:0] seed, input int poke);
    int lat;
    plan(sel, nv, seed);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1 set_start(sel, 1'b0);
    lat = -1;
    for (int k = 1; k <= nv + 20; k++) begin
      if (k == poke) set_start(sel, 1'b1);
      @(posedge clk);
      #1 set_start(sel, 1'b0);
      if (get_done(sel)) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL done_timeout dut=%0d actual=none required=%0d", sel, nv);
      vq.delete();
      fq.delete();
    end else begin
      check("done_latency", lat, nv);
    end
    repeat (3) @(posedge clk);
    #1;
    check("hold_vec_count", get_vc(sel), nv);
    check("hold_done", get_done(sel), 1'b1);
  endtask

  task automatic check_d0_zero(input string tag);
    check({tag, "_a"}, d0_a, 4'h0);
    check({tag, "_b"}, d0_b, 4'h0);
    check({tag, "_op"}, d0_op, 3'h0);
    check({tag, "_busy"}, d0_busy, 1'b0);
    check({tag, "_done"}, d0_done, 1'b0);
    check({tag, "_pass"}, d0_pass, 1'b0);
    check({tag, "_vc"}, d0_vc, 16'h0);
    check({tag, "_ec"}, d0_ec, 16'h0);
    check({tag, "_fev"}, d0_fev, 1'b0);
    check({tag, "_fe"}, d0_fe, 11'h0);
  endtask

  initial begin
    d0_start = 1'b0;
    d1_start = 1'b0;
    d2_start = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_d0_zero("reset");
    check("reset_d1_vc", d1_vc, 16'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Good ALU, then a restart from DONE with an identical expected outcome.
    fmode = 0;
    run(0, 4, SEED0, 0);
    check("good_pass", d0_pass, 1'b1);
    run(0, 4, SEED0, 0);

    // Zero flag stuck at 0: vector 1 (AND 0,7 -> 0) is the first failure.
    fmode = 1;
    run(0, 4, SEED0, 0);
    check("stuck_first_err_vec", d0_fe, 11'h207);
    check("stuck_pass", d0_pass, 1'b0);

    // start during RUN is ignored.
    fmode = 0;
    run(0, 4, SEED0, 2);

    // Reset after two vectors have been checked.
    plan(0, 4, SEED0);
    @(negedge clk);
    d0_start = 1'b1;
    @(posedge clk);
    #1 d0_start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_d0_zero("midrun_reset");
    vq.delete();
    fq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    plan(0, 4, SEED0);
    @(negedge clk);
    d0_start = 1'b1;
    @(posedge clk);
    #1 d0_start = 1'b0;
    check("after_reset_vec0", {d0_op, d0_a, d0_b}, {3'd4, 4'h1, 4'hE});
    repeat (6) @(posedge clk);
    #1 check("after_reset_done", d0_done, 1'b1);

    // Single-vector run.
    run(2, 1, SEED2, 0);

    // Long runs with zero seed, random fault classes and random start pokes.
    for (int r = 0; r < 4; r++) begin
      fmode = (r == 0) ? 0 : (r == 3) ? 1 : 2;
      fkey  = int'($urandom_range(0, 6));
      run(1, 200, SEED1, int'($urandom_range(1, 199)));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_vec_empty", vq.size(), 0);
    check("scoreboard_fin_empty", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
